mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the registered ALU result as a data-RAM word address and performs a load, store or pass-through of that result.
- Drives a synchronous single-port data RAM with fixed read latency.
- Hands the write-back value to the next stage over a valid/ready handshake.

Parameters:
ADDR_W, 10, RAM word-address width; must match the ALU's 10-bit RAM address output
DATA_W, 32, data width of the ALU result, store data and RAM words
MEM_LAT, 1, RAM read latency in cycles from the ram_en cycle to ram_rdata valid; legal range 1..4

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream request valid
in_ready  out  1  stage can accept a request
mem_op  in  2  00 pass ALU result, 01 load word, 10 store word, 11 reserved (treated as pass)
alu_result  in  DATA_W  ALU output: pass value, or word address for load/store
store_data  in  DATA_W  data for a store
rd_in  in  5  destination register tag
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable; only meaningful with ram_en
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
out_valid  out  1  write-back result valid
out_ready  in  1  downstream accepts the result
out_data  out  DATA_W  load data or passed ALU result
out_rd  out  5  destination tag
out_wb  out  1  1 = register write required (load or pass); 0 for store or error
addr_err  out  1  request address was out of range

Behaviour:
- States: IDLE, WRITE, READ, OUT.
- in_ready = 1 only in IDLE. A request is accepted on an edge where in_valid && in_ready. The accept edge closes cycle 0.
- Request fields are registered at accept.
- Range check: alu_result[DATA_W-1:ADDR_W] != 0 on a load or store is an error.
  - No RAM access is made.
  - State goes to OUT with addr_err=1, out_wb=0, out_data=alu_result.
- Pass (00/11): IDLE -> OUT. out_valid=1 in cycle 1, out_data=alu_result, out_wb=1.
- Store: IDLE -> WRITE.
  - Cycle 1: ram_en=1, ram_we=1, ram_addr=alu_result[ADDR_W-1:0], ram_wdata=store_data.
  - WRITE -> OUT. out_valid=1 in cycle 2, out_wb=0, out_data=store_data.
- Load: IDLE -> READ.
  - Cycle 1: ram_en=1, ram_we=0, ram_addr as above.
  - A counter in READ counts MEM_LAT cycles. ram_rdata is sampled at the end of cycle 1+MEM_LAT.
  - READ -> OUT. out_valid=1 in cycle 2+MEM_LAT, out_data=sampled word, out_wb=1.
- ram_en and ram_we are high for exactly one cycle per access and 0 in all other cycles. ram_addr and ram_wdata hold their last value when idle.
- OUT:
  - out_valid=1. out_data, out_rd, out_wb and addr_err are held stable until an edge with out_ready=1.
  - On that edge: OUT -> IDLE, and out_valid drops in the next cycle.
  - No new request is accepted in the same edge the result leaves, so the maximum throughput for a pass is one request per 2 cycles.
- out_ready is ignored outside OUT. in_valid is ignored outside IDLE.
- Reset values, and behaviour on reset at any point, including mid-READ or mid-WRITE:
  - state=IDLE, counter=0.
  - All outputs 0, except in_ready=1 after reset deasserts.
  - An in-flight RAM access is abandoned; late ram_rdata is never captured.

Optional Feature:
- Macro: MEM_FWD_EN.
- When defined:
  - The stage keeps a last-store register {fwd_valid, fwd_addr, fwd_data}, written on every store issue.
  - A load whose address equals fwd_addr while fwd_valid=1 skips the RAM: ram_en stays 0, IDLE -> OUT, out_valid in cycle 1, out_data=fwd_data.
  - reset clears fwd_valid.
  - Out-of-range requests never update or hit the register.
- When undefined: no forwarding register; every load follows the READ path with latency MEM_LAT+2.

Test Plan:
1. reset held 3 cycles mid-load, then released -> all outputs 0, ram_en stays 0, in_ready=1 in the first cycle after release.
2. Pass, alu_result=0x0000_1234, out_ready=1 -> out_valid in cycle 1, out_data=0x1234, out_wb=1; in_ready returns in cycle 2.
3. Store addr 0x005 data 0xDEADBEEF, then load addr 0x005, MEM_LAT=2 -> ram_we pulse of 1 cycle at addr 5; load out_valid in cycle 4 after its accept, out_data=0xDEADBEEF.
4. Load alu_result=0x0000_0400 -> addr_err=1, out_wb=0, ram_en never asserted, out_valid in cycle 1.
5. Pass with out_ready held 0 for 5 cycles -> out_valid, out_data and out_rd stable all 5 cycles, in_ready=0; single hand-off on the edge out_ready=1.
6. MEM_FWD_EN: store addr 0x010 data 0xA5A5A5A5, then load 0x010 -> ram_en stays 0 for the load, out_data=0xA5A5A5A5 in cycle 1. Without the macro the same sequence gives latency MEM_LAT+2.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store/pass memory-access stage driving a synchronous data RAM
// Optional store-to-load forwarding register enabled by `define MEM_FWD_EN.
module mem_access_stage #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mem_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        rd_in,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_wb,
    output logic              addr_err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, OUT} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t            state;
    state_t            state_nx;
    logic [2:0]        cnt;
    logic              accept;
    logic              is_ld;
    logic              is_st;
    logic              range_err;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data_w;

    assign is_ld     = (mem_op == 2'b01);
    assign is_st     = (mem_op == 2'b10);
    assign range_err = |alu_result[DATA_W-1:ADDR_W];
    assign in_ready  = (state == IDLE) && !reset;
    assign accept    = in_valid && in_ready;

    // RAM strobe is a single cycle: the WRITE cycle, or the first READ cycle
    assign ram_en    = !reset && ((state == WRITE) || ((state == READ) && (cnt == 3'd0)));
    assign ram_we    = !reset && (state == WRITE);
    assign out_valid = !reset && (state == OUT);

`ifdef MEM_FWD_EN
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;

    assign fwd_hit    = fwd_valid && (fwd_addr == alu_result[ADDR_W-1:0]);
    assign fwd_data_w = fwd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if (accept && is_st && !range_err) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= alu_result[ADDR_W-1:0];
            fwd_data  <= store_data;
        end
    end
`else
    assign fwd_hit    = 1'b0;
    assign fwd_data_w = '0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((is_ld || is_st) && range_err) state_nx = OUT;
                    else if (is_st)                    state_nx = WRITE;
                    else if (is_ld && !fwd_hit)        state_nx = READ;
                    else                               state_nx = OUT;
                end
            end
            WRITE:   state_nx = OUT;
            READ:    if (cnt == LAT) state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            out_data  <= '0;
            out_rd    <= '0;
            out_wb    <= 1'b0;
            addr_err  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_rd <= rd_in;
                        cnt    <= 3'd0;
                        if ((is_ld || is_st) && range_err) begin
                            out_data <= alu_result;
                            out_wb   <= 1'b0;
                            addr_err <= 1'b1;
                        end else if (is_st) begin
                            ram_addr  <= alu_result[ADDR_W-1:0];
                            ram_wdata <= store_data;
                            out_data  <= store_data;
                            out_wb    <= 1'b0;
                            addr_err  <= 1'b0;
                        end else if (is_ld) begin
                            out_wb   <= 1'b1;
                            addr_err <= 1'b0;
                            if (fwd_hit) out_data <= fwd_data_w;
                            else         ram_addr <= alu_result[ADDR_W-1:0];
                        end else begin
                            out_data <= alu_result;
                            out_wb   <= 1'b1;
                            addr_err <= 1'b0;
                        end
                    end
                end
                READ: begin
                    // ram_rdata is valid in the last READ cycle, MEM_LAT cycles after the strobe
                    if (cnt == LAT) out_data <= ram_rdata;
                    else            cnt      <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
